seg_bcd_converter: RTL
======================

Name: seg_bcd_converter

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It sits directly upstream of the eight-digit seven-segment display controller. It takes the raw binary value software writes to the digits register and produces the packed BCD nibbles that the digit multiplexer consumes. It replaces the combinational divide/modulo path with an iterative one-bit-per-cycle engine.

Parameters:
BIN_W, 32, width of binary input; must be >= 1.
DIGITS, 8, number of BCD output digits; output width is DIGITS*4; must be >= 1.

Ports:
clk  in  1  system clock.
rst_n  in  1  reset, asynchronous, active-low.
i_bin  in  BIN_W  binary value to convert; sampled only on accept.
i_valid  in  1  request; conversion is accepted when i_valid & o_ready at a clk edge.
o_ready  out  1  high only in IDLE.
i_abort  in  1  synchronous abort of an in-flight conversion.
o_bcd  out  DIGITS*4  last completed result; digit 0 is in [3:0], digit k is in [4k+3:4k].
o_ovf  out  1  last completed value was >= 10^DIGITS.
o_valid  out  1  one-cycle pulse when o_bcd/o_ovf update.
o_busy  out  1  conversion in flight (SHIFT or DONE).

Behaviour:
- Reset (async assert, sync release) sets: state=IDLE; o_bcd=0; o_ovf=0; o_valid=0; o_busy=0; o_ready=1. Internal scratch and counter are cleared.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - o_ready=1.
  - On accept: latch i_bin into a shift register, clear BCD scratch (DIGITS*4 bits), clear the sticky overflow bit, load the bit counter with BIN_W, and go to SHIFT.
  - i_abort in IDLE has no effect.
- SHIFT: one input bit per cycle, MSB first. In each cycle:
  - every scratch nibble >= 5 gets +3, all nibbles evaluated in parallel;
  - the adjusted scratch shifts left 1, with the input MSB entering bit 0;
  - the bit shifted out of scratch MSB is ORed into the sticky overflow bit;
  - the counter decrements.
  - When the counter reaches 0 after the BIN_W-th shift, go to DONE.
- DONE (one cycle): o_bcd<=scratch, o_ovf<=sticky, o_valid pulses high for exactly one cycle, then go to IDLE.
- Latency: accept at edge k. Shifts occur at edges k+1 through k+BIN_W. DONE is entered at edge k+BIN_W. o_bcd, o_ovf and o_valid are registered at edge k+BIN_W+1, and o_valid is high for the following cycle. o_ready returns to 1 in that same cycle. Minimum spacing between accepts is BIN_W+2 cycles.
- i_valid while busy is ignored; the request is not queued. i_bin changing while busy has no effect.
- o_bcd and o_ovf hold their value between completions and are never partially updated.
- Overflow: when the value is >= 10^DIGITS, o_bcd = value mod 10^DIGITS (the natural truncated double-dabble result) and o_ovf=1.
- i_abort in SHIFT or DONE: go to IDLE next edge, no o_valid, o_bcd/o_ovf unchanged. i_abort takes priority over the DONE update when both fall on the same edge.
- Reset asserted mid-conversion: all outputs go immediately to their reset values.
- Digit adjust uses 4-bit compare and add; no carries cross nibbles before the shift.

Test Plan:
1. Reset: hold rst_n=0, check asynchronously -> o_bcd=0, o_ovf=0, o_valid=0, o_busy=0, o_ready=1. Release and check o_ready=1.
2. Accept i_bin=12345678 (0x00BC614E) at edge k -> o_ready=0 from k+1; o_valid high exactly in the cycle after edge k+33; o_bcd=0x12345678; o_ovf=0.
3. Boundaries:
   - i_bin=0 -> o_bcd=0x00000000, o_ovf=0.
   - i_bin=99999999 -> 0x99999999, o_ovf=0.
   - i_bin=100000000 -> 0x00000000, o_ovf=1.
   - i_bin=0xFFFFFFFF -> 0x94967295, o_ovf=1.
4. Back-to-back:
   - Hold i_valid=1 with 5 then 42 -> exactly two o_valid pulses, results 0x5 and 0x42, spaced 34 cycles.
   - Pulses of i_valid during SHIFT are ignored, so no third result appears.
5. Abort: convert 777 to completion, then start 123 and assert i_abort on the 10th SHIFT cycle -> no o_valid; o_bcd stays 0x00000777; o_ready=1 next cycle; a new accept of 123 gives 0x00000123.
6. Reset mid-SHIFT (cycle 15 of conversion of 555) -> outputs go to reset values immediately. After release, accepting 9 gives o_bcd=0x00000009 at the normal latency.

Source files
------------

// File: rtl/seg_bcd_converter.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Feeds packed BCD digits to the seven-segment digit multiplexer.
module seg_bcd_converter #(
   parameter int BIN_W  = 32,
   parameter int DIGITS = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [BIN_W-1:0]      i_bin,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic                  i_abort,
   output logic [DIGITS*4-1:0]   o_bcd,
   output logic                  o_ovf,
   output logic                  o_valid,
   output logic                  o_busy
);

   localparam int SCR_W = DIGITS * 4;
   localparam int CNT_W = $clog2(BIN_W + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [1:0]       state;
   logic [BIN_W-1:0] bin_sr;
   logic [SCR_W-1:0] scratch;
   logic [SCR_W-1:0] adj;
   logic [SCR_W-1:0] scratch_nxt;
   logic             sticky;
   logic [CNT_W-1:0] cnt;

   // Each nibble is corrected on its own; the +3 never carries into the
   // next digit because a nibble of 5..9 plus 3 stays within 4 bits.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
      adj = scratch;
      for (int d = 0; d < DIGITS; d++) begin
         if (scratch[4*d +: 4] >= 4'd5) begin
            adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
         end
      end
   end

   assign scratch_nxt = {adj[SCR_W-2:0], bin_sr[BIN_W-1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
         state   <= ST_IDLE;
         bin_sr  <= '0;
         scratch <= '0;
         sticky  <= 1'b0;
         cnt     <= '0;
         o_bcd   <= '0;
         o_ovf   <= 1'b0;
         o_valid <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               // i_abort is meaningless here; nothing is in flight.
               if (i_valid) begin
                  bin_sr  <= i_bin;
                  scratch <= '0;
                  sticky  <= 1'b0;
                  cnt     <= CNT_LOAD;
                  state   <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (i_abort) begin
                  state <= ST_IDLE;
               end else begin
                  scratch <= scratch_nxt;
                  bin_sr  <= bin_sr << 1;
                  // Anything leaving the top digit means value >= 10^DIGITS.
                  sticky  <= sticky | adj[SCR_W-1];
                  cnt     <= cnt - CNT_ONE;
                  if (cnt == CNT_ONE) begin
                     state <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               // Abort wins over the publish, so the old result is kept whole.
               if (!i_abort) begin
                  o_bcd   <= scratch;
                  o_ovf   <= sticky;
                  o_valid <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_ready = (state == ST_IDLE);
   assign o_busy  = (state != ST_IDLE);

endmodule
